soc_mem2_reader: RTL and testbench
==================================

SOC_MEM2_READER -- requirements
Module: soc_mem2_reader

Interface
REQ-001 SHALL have parameters, one per line: ADDR_W, 10, memory word-address width; DATA_W, 32, memory data width; FIFO_DEPTH, 4, output buffer depth in words (power of 2, at least 2).
REQ-002 SHALL have ports, one per line: clk  in  1  sole clock, all logic on rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle request to begin a block read.
REQ-005 base_addr  in  ADDR_W  first word address, sampled when start is accepted.
REQ-006 length  in  ADDR_W+1  word count (0..1024), sampled when start is accepted.
REQ-007 busy  out  1  high from accepted start until done.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 mem_address, mem_chipselect, mem_write, mem_byteenable[3:0], mem_clken  out  master side of the 32-bit memory port.
REQ-010 mem_readdata  in  DATA_W  read data, valid exactly 1 cycle after an issued read.
REQ-011 st_data  out  DATA_W, st_valid  out  1, st_ready  in  1, st_last  out  1  stream source.

Function
REQ-012 SHALL tie mem_write to 0 and mem_byteenable to 4'hF, and SHALL hold mem_clken at 1.
REQ-013 SHALL implement states IDLE, READ, DRAIN.
REQ-014 In IDLE, start with length>0 SHALL latch base_addr and length and enter READ; busy SHALL rise the next cycle.
REQ-015 In IDLE, start with length==0 SHALL produce a done pulse on the next cycle, stay in IDLE, and issue no reads.
REQ-016 start SHALL be ignored while busy.
REQ-017 In READ, the block SHALL issue one read per cycle (mem_chipselect=1) only when (fifo_count + inflight) < FIFO_DEPTH, so read data never overflows the buffer.
REQ-018 mem_address SHALL increment by 1 per issued read and wrap modulo 2^ADDR_W (0x3FF to 0x000).
REQ-019 After length reads have been issued, the block SHALL enter DRAIN.
REQ-020 The block SHALL capture mem_readdata into the FIFO on the cycle after each issued read, unconditionally.
REQ-021 st_valid SHALL be high whenever the FIFO is non-empty; a word is consumed when st_valid and st_ready are both high.
REQ-022 st_data and st_valid SHALL stay stable while st_valid=1 and st_ready=0.
REQ-023 st_last SHALL be high only with the length-th word of the block.
REQ-024 In DRAIN, the handshake of the st_last word SHALL cause done=1 for one cycle on the next cycle, together with a return to IDLE and busy=0.
REQ-025 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-026 An internal word counter SHALL be ADDR_W+1 bits wide so that length=1024 is representable.

Reset
REQ-027 Reset SHALL force, asynchronously: state=IDLE, busy=0, done=0, st_valid=0, st_last=0, mem_chipselect=0, mem_address=0, FIFO empty, counters 0.
REQ-028 Reset asserted mid-block SHALL abort the block with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-029 A shared package soc_mem2_pkg SHALL hold the state enum and the ADDR_W, DATA_W and FIFO_DEPTH defaults.
REQ-030 The output buffer SHALL be a single sub-module soc_mem2_rd_fifo (synchronous FIFO, show-ahead, count output).

Verification
REQ-031 base=0x010, length=4, st_ready=1 -> addresses 0x010..0x013 on consecutive cycles, 4 words in order, st_last on word 4, done 1 cycle after its handshake.
REQ-032 base=0x3FE, length=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-033 length=16, st_ready=0 for 20 cycles then 1 -> exactly 4 reads issued during the stall, no word lost or duplicated, all 16 delivered.
REQ-034 length=0 -> no mem_chipselect, done pulse 1 cycle after start; start during busy -> ignored, block unchanged.
REQ-035 reset pulsed after 3 words of a length=8 block -> all outputs at reset values, no done; a new start with length=2 completes normally.
REQ-036 length=1024, random st_ready -> 1024 words delivered, st_last only on word 1024, done once.

Source files
------------

// File: rtl/soc_mem2_pkg.sv
// soc_mem2_pkg: shared state encoding and default widths for the block reader
package soc_mem2_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 4;
endpackage

// File: rtl/soc_mem2_rd_fifo.sv
// soc_mem2_rd_fifo: show-ahead sync FIFO (push/din in, pop/dout/empty/count out)
module soc_mem2_rd_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
endmodule

// File: rtl/soc_mem2_reader.sv
// soc_mem2_reader: reads length words from base_addr over the memory port and streams them out
module soc_mem2_reader
  import soc_mem2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic [ADDR_W:0] rd_left;
  logic inflight, inflight_last, fifo_empty, pop;
  logic [CW-1:0] fifo_count;
  logic [CW:0] occ;
  logic [DATA_W:0] fifo_dout;
  assign mem_write = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken = 1'b1;
  assign occ = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign mem_chipselect = state == READ && occ < (CW+1)'(FIFO_DEPTH);
  assign st_valid = !fifo_empty;
  assign st_data = fifo_dout[DATA_W-1:0];
  assign st_last = st_valid && fifo_dout[DATA_W];
  assign pop = st_valid && st_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      mem_address <= '0;
      rd_left <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      done <= 1'b0;
      inflight <= mem_chipselect;
      inflight_last <= mem_chipselect && rd_left == (ADDR_W+1)'(1);
      if (mem_chipselect) begin
        mem_address <= mem_address + 1'b1;
        rd_left <= rd_left - 1'b1;
      end
      case (state)
        IDLE:
          if (start) begin
            if (length == '0) done <= 1'b1;
            else begin
              state <= READ;
              busy <= 1'b1;
              mem_address <= base_addr;
              rd_left <= length;
            end
          end
        READ: if (mem_chipselect && rd_left == (ADDR_W+1)'(1)) state <= DRAIN;
        DRAIN:
          if (pop && st_last) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  soc_mem2_rd_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(inflight),
    .din({inflight_last, mem_readdata}),
    .pop(pop),
    .dout(fifo_dout),
    .count(fifo_count),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_soc_mem2_reader.sv
// tb_soc_mem2_reader: randomized block reads checked against an array-based memory/stream model
module tb_soc_mem2_reader;
  localparam int AW = 10, DW = 32, FD = 4;
  logic clk = 0, reset = 1, start = 0, st_ready = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] length = '0;
  logic busy, done, mem_chipselect, mem_write, mem_clken, st_valid, st_last;
  logic [AW-1:0] mem_address;
  logic [3:0] mem_byteenable;
  logic [DW-1:0] mem_readdata = '0, st_data;
  int checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] mem_img [1024];
  logic [AW-1:0] addr_q[$];
  int addr_cyc[$], hs_cyc[$];
  logic [DW:0] word_q[$];
  int done_cnt = 0, done_cyc = -1, stall_reads = 0;
  logic pv = 0, pr = 0;
  logic [DW-1:0] pd = '0;

  soc_mem2_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_last(st_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory with one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_chipselect) mem_readdata <= mem_img[mem_address];
  end

  always @(negedge clk)
    if (reset) begin
      pv = 0;
      pr = 0;
    end else begin
      if (mem_chipselect) begin
        addr_q.push_back(mem_address);
        addr_cyc.push_back(cyc);
        if (!st_ready) stall_reads++;
      end
      if (st_valid && st_ready) begin
        word_q.push_back({st_last, st_data});
        hs_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pv && !pr) begin
        check("hold_valid", st_valid, 1);
        check("hold_data", st_data, pd);
      end
      pv = st_valid;
      pr = st_ready;
      pd = st_data;
    end

  task automatic clear_mon();
    addr_q.delete();
    addr_cyc.delete();
    word_q.delete();
    hs_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    stall_reads = 0;
  endtask

  // mode 0: st_ready=1, mode 1: random st_ready, mode 2: st_ready=0 for 20 cycles then 1
  task automatic run_block(input logic [AW-1:0] b, input int len, input int mode, input bit poke);
    int t, start_cyc;
    logic [AW-1:0] ea;
    logic [DW:0] e;
    clear_mon();
    @(posedge clk); #1;
    base_addr = b;
    length = len[AW:0];
    start = 1;
    st_ready = mode == 0;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    base_addr = AW'($urandom);
    length = (AW+1)'($urandom);
    check("busy_rise", busy, len > 0);
    if (len == 0) check("zero_done_now", done, 1);
    t = 0;
    while (done_cnt == 0 && t < 20000) begin
      @(posedge clk); #1;
      t++;
      if (mode == 1) st_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) st_ready = t >= 20;
      start = poke && t == 5 && busy;
      if (start) begin
        base_addr = AW'($urandom);
        length = (AW+1)'($urandom_range(1, 50));
      end
    end
    start = 0;
    check("timeout", t < 20000, 1);
    repeat (4) @(posedge clk);
    #1;
    check("busy_end", busy, 0);
    check("done_cnt", done_cnt, 1);
    check("n_reads", addr_q.size(), len);
    check("n_words", word_q.size(), len);
    if (addr_q.size() == len && word_q.size() == len) begin
      for (int i = 0; i < len; i++) begin
        ea = b + AW'(i);
        e = {i == len - 1, mem_img[ea]};
        check("addr", addr_q[i], ea);
        check("word", word_q[i], e);
      end
      if (len > 0) check("done_lat", done_cyc, hs_cyc[len-1] + 1);
      else check("zero_lat", done_cyc, start_cyc + 1);
      if (mode == 0 && len > 0) check("addr_consec", addr_cyc[len-1] - addr_cyc[0], len - 1);
    end
    if (mode == 2) check("stall_reads", stall_reads, 4);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, st_valid, 0);
    check({tag, "_last"}, st_last, 0);
    check({tag, "_cs"}, mem_chipselect, 0);
    check({tag, "_addr"}, mem_address, 0);
  endtask

  initial begin
    int t;
    foreach (mem_img[i]) mem_img[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    check("ties", {mem_write, mem_byteenable, mem_clken}, {1'b0, 4'hF, 1'b1});
    reset = 0;
    run_block(10'h010, 4, 0, 0);
    run_block(10'h3FE, 4, 0, 0);
    run_block(AW'($urandom), 16, 2, 0);
    run_block(AW'($urandom), 0, 0, 0);
    run_block(AW'($urandom), 12, 1, 1);
    // abort a length-8 block after 3 words
    clear_mon();
    @(posedge clk); #1;
    base_addr = AW'($urandom);
    length = 8;
    start = 1;
    st_ready = 1;
    @(posedge clk); #1;
    start = 0;
    t = 0;
    while (word_q.size() < 3 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("abort_timeout", t < 100, 1);
    #2 reset = 1;
    #1 check_reset_vals("abort");
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    run_block(AW'($urandom), 2, 0, 0);
    run_block(AW'($urandom), 1024, 1, 0);
    for (int k = 0; k < 6; k++) run_block(AW'($urandom), $urandom_range(1, 40), 1, k[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
